muldiv_unit: RTL and testbench

Iterative, parametrised multiply/divide unit with architectural Hi/Lo registers, replacing the CPU's combinational multiplier. Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. Takes operands from the ALU operand muxes (opA/opB) and feeds Hi/Lo to the register write-back mux. Uses a start/busy/done handshake, so the decoder stalls the PC while busy.

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with architectural Hi/Lo registers
// Radix-2 shift-add multiply and restoring divide on magnitudes, with signs applied in FIX.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  // Signed forms are MULT (0) and DIV (2); most-negative maps onto its own unsigned magnitude.
  assign sign_a = ~op[0] & opA[WIDTH-1];
  assign sign_b = ~op[0] & opB[WIDTH-1];
  assign mag_a  = sign_a ? -opA : opA;
  assign mag_b  = sign_b ? -opB : opB;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

  // Divide: the dividend/quotient shifts out of acc's low half MSB-first; diff[W] is the borrow.
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  assign prod = neg_q ? -acc_q : acc_q;
  assign quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    b_d       = b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              if (op[1] && opB == '0) begin
                dbz_d  = 1'b1;
                done_d = 1'b1;
              end else begin
                is_div_d  = op[1];
                neg_d     = sign_a ^ sign_b;
                neg_rem_d = sign_a;
                cnt_d     = CNT_INIT;
                rem_d     = '0;
                acc_d     = {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                b_d       = op[1] ? mag_b : mag_a;
                dbz_d     = 1'b0;
                busy_d    = 1'b1;
                state_d   = CALC;
              end
            end
            3'd4: begin
              hi_d   = opA;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            3'd5: begin
              lo_d   = opA;
              dbz_d  = 1'b0;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div_q) begin
          rem_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(1)) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          hi_d = rem;
          lo_d = quot;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      b_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      b_q       <= b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8
// Latency is counted in rising edges after the edge that samples start.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        s32, busy32, done32, dz32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, hi32, lo32;
  logic        s8, busy8, done8, dz8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;

  muldiv_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(s32), .op(op32), .opA(a32), .opB(b32),
    .busy(busy32), .done(done32), .div_by_zero(dz32), .hi(hi32), .lo(lo32)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(s8), .op(op8), .opA(a8), .opB(b8),
    .busy(busy8), .done(done8), .div_by_zero(dz8), .hi(hi8), .lo(lo8)
  );

  int n_vec = 0;
  int n_err = 0;
  int lat;
  int ndone;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic go32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    s32 = 1'b1; op32 = o; a32 = a; b32 = b;
    @(posedge clk);
    #1 s32 = 1'b0;
  endtask

  task automatic wait32(output int l);
    l = 0;
    while (!done32 && l < 100) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  task automatic go8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    s8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk);
    #1 s8 = 1'b0;
  endtask

  task automatic wait8(output int l);
    l = 0;
    while (!done8 && l < 40) begin
      @(posedge clk);
      #1 l++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    s32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    s8 = 1'b0;  op8 = '0;  a8 = '0;  b8 = '0;
    #12;
    chk("rst_hilo32", {hi32, lo32}, 64'h0);
    chk("rst_flags32", {busy32, done32, dz32}, 3'b000);
    chk("rst_hilo8", {hi8, lo8}, 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset in the middle of CALC aborts with no Hi/Lo update
    go32(3'd1, 32'd5, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    chk("midcalc_busy", busy32, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("midcalc_rst_hilo", {hi32, lo32}, 64'h0);
    chk("midcalc_rst_flags", {busy32, done32}, 2'b00);
    @(negedge clk);
    reset_n = 1'b1;
    go32(3'd1, 32'd5, 32'd7);
    wait32(lat);
    chk("multu_5x7_lat", lat, 33);
    chk("multu_5x7", {hi32, lo32}, 64'h00000000_00000023);

    go32(3'd0, 32'hFFFFFFFF, 32'd2);
    wait32(lat);
    chk("mult_m1x2_lat", lat, 33);
    chk("mult_m1x2", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFFE);
    @(posedge clk);
    #1 chk("mult_done_width", done32, 1'b0);

    go32(3'd1, 32'hFFFFFFFF, 32'd2);
    wait32(lat);
    chk("multu_ffx2", {hi32, lo32}, 64'h00000001_FFFFFFFE);

    go32(3'd2, 32'hFFFFFFF9, 32'd2);
    wait32(lat);
    chk("div_m7_2_lat", lat, 33);
    chk("div_m7_2", {hi32, lo32}, 64'hFFFFFFFF_FFFFFFFD);

    go32(3'd3, 32'd100, 32'd7);
    wait32(lat);
    chk("divu_100_7", {hi32, lo32}, 64'h00000002_0000000E);

    go32(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait32(lat);
    chk("div_ovf", {hi32, lo32, dz32}, {64'h00000000_80000000, 1'b0});

    // MTHI preload, then divide by zero leaves Hi/Lo alone
    go32(3'd4, 32'h0000AAAA, 32'd0);
    wait32(lat);
    chk("mthi_lat", lat, 0);
    chk("mthi_hi", hi32, 32'h0000AAAA);
    go32(3'd3, 32'd100, 32'd0);
    chk("dbz_busy", busy32, 1'b0);
    wait32(lat);
    chk("dbz_lat", lat, 0);
    chk("dbz_flag", dz32, 1'b1);
    chk("dbz_hilo", {hi32, lo32}, 64'h0000AAAA_80000000);
    go32(3'd5, 32'h00001234, 32'd0);
    wait32(lat);
    chk("mtlo_clr_dbz", {dz32, lo32, hi32}, {1'b0, 32'h00001234, 32'h0000AAAA});

    // Starts during CALC are dropped; opB change mid-CALC has no effect
    go32(3'd0, 32'd3, 32'hFFFFFFFB);
    ndone = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      s32 = (i == 5 || i == 20);
      op32 = 3'd3;
      b32 = 32'd0;
      @(posedge clk);
      #1;
      if (done32) begin
        ndone++;
        if (lat < 0) lat = i;
      end
    end
    s32 = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_lat", lat, 33);
    chk("ign_result", {hi32, lo32, dz32}, {64'hFFFFFFFF_FFFFFFF1, 1'b0});

    // A start issued while done is high is accepted
    go32(3'd3, 32'd100, 32'd7);
    wait32(lat);
    chk("b2b_first", lo32, 32'd14);
    go32(3'd1, 32'd6, 32'd7);
    wait32(lat);
    chk("b2b_lat", lat, 33);
    chk("b2b_second", {hi32, lo32}, 64'h00000000_0000002A);

    // WIDTH=8 instance
    go8(3'd0, 8'h80, 8'h80);
    wait8(lat);
    chk("w8_mult_lat", lat, 9);
    chk("w8_mult", {hi8, lo8}, 16'h4000);
    @(posedge clk);
    #1 chk("w8_done_width", done8, 1'b0);
    go8(3'd2, 8'h81, 8'h03);
    wait8(lat);
    chk("w8_div", {hi8, lo8}, 16'hFFD6);
    go8(3'd3, 8'hFF, 8'h10);
    wait8(lat);
    chk("w8_divu", {hi8, lo8}, 16'h0F0F);
    go8(3'd6, 8'h12, 8'h34);
    ndone = 0;
    repeat (5) begin
      if (done8 || busy8) ndone++;
      @(posedge clk);
      #1;
    end
    chk("w8_reserved_op", ndone, 0);
    chk("w8_reserved_hilo", {hi8, lo8}, 16'h0F0F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
